// File: rtl/loader_pkg.sv
// Shared types and image-format constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         LEN_BYTES      = 2;
    localparam int         HDR_BYTES      = 1 + LEN_BYTES;

    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/program_loader_byte_to_word.sv
// Big-endian byte-to-word assembler: four shifted bytes form one 32-bit word.
module byte_to_word
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = 32'd0;
        end else if (shift_en) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {word_q[23:0], byte_in};
        end
    end

    // Asserted alongside the byte that completes the word, so the caller can
    // branch on the same edge that latches it.
    assign word_full = shift_en && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word      = word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory
// and releases the core reset only once the image has been verified.
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        load_req,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       len_full;
    logic              accept;
    logic              shift_clear;
    logic              shift_en;
    logic              word_full;
    logic [31:0]       word;

    assign accept = rx_valid && rx_ready;

    byte_to_word u_b2w (
        .clk      (clk),
        .rst      (rst),
        .clear    (shift_clear),
        .shift_en (shift_en),
        .byte_in  (rx_data),
        .word_full(word_full),
        .word     (word)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        len_full    = {len_q[15:8], rx_data};
        shift_clear = (state_q == S_IDLE);
        shift_en    = accept && (state_q == S_DATA);

        case (state_q)
            S_IDLE: begin
                // Holding these cleared while idle covers every entry path.
                word_idx_d = '0;
                csum_d     = 8'd0;
                if (accept && rx_data == MAGIC) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > MAX_WORDS) state_d = S_ERR;
                    else if (len_full == 16'd0)       state_d = S_CSUM;
                    else                              state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_next(csum_q, rx_data);
                    if (word_full) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + (ADDR_W + 1)'(1);
                if (17'(word_idx_d) == {1'b0, len_q}) state_d = S_CSUM;
                else                                  state_d = S_DATA;
            end
            S_CSUM: begin
                if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (load_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            word_idx_q <= '0;
            csum_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
        end
    end

    assign rx_ready   = (state_q inside {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM});
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = 32'(word_idx_q) << 2;
    assign imem_wdata = word;
    assign core_rst_n = (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign busy       = !(state_q inside {S_IDLE, S_DONE, S_ERR});

endmodule
